// File: rtl/processor_pkg.sv
// Shared definitions for the processor slice: word widths, the default
// instruction-store depth and the program loader state encoding.
package processor_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int BYTE_WIDTH    = 8;
  localparam int DEFAULT_DEPTH = 256;

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    OPC_HI,
    OPC_LO,
    OPR_HI,
    OPR_LO,
    WRITE,
    CHK,
    DONE,
    ERROR
  } loader_state_t;

  // States in which the loader is waiting for a byte of the frame
  function automatic logic accepts_bytes(input loader_state_t s);
    return s inside {LEN_HI, LEN_LO, OPC_HI, OPC_LO, OPR_HI, OPR_LO, CHK};
  endfunction

endpackage

// File: rtl/loader_xor_acc.sv
// Running 8-bit XOR of the program image bytes, used to validate the
// trailing checksum byte of a frame.
module loader_xor_acc (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] byte_in,
  output logic [7:0] acc
);

  // Fold each enabled byte into the accumulator; clear restarts a frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      acc <= 8'h00;
    else if (clear)
      acc <= 8'h00;
    else if (enable)
      acc <= acc ^ byte_in;
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a framed program image over an 8-bit valid/ready
// byte stream, assembles each 4-byte record into an opcode/operand pair,
// writes it to the instruction store and keeps the processor in reset until
// the whole image has been loaded.
// Optional trailing checksum byte: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int DEPTH      = processor_pkg::DEFAULT_DEPTH,
  parameter int DATA_WIDTH = processor_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_opcode,
  output logic [DATA_WIDTH-1:0] mem_operand,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  import processor_pkg::*;

  localparam logic [DATA_WIDTH:0] DEPTH_LIMIT = (DATA_WIDTH+1)'(DEPTH);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam loader_state_t AFTER_LAST = CHK;
`else
  localparam loader_state_t AFTER_LAST = DONE;
`endif

  loader_state_t state;
  loader_state_t next_state;

  logic [DATA_WIDTH-1:0] len_q;
  logic [DATA_WIDTH-1:0] count_q;
  logic [DATA_WIDTH-1:0] opc_q;
  logic [DATA_WIDTH-1:0] opr_q;
  logic [DATA_WIDTH-1:0] len_word;
  logic [DATA_WIDTH-1:0] count_next;
  logic                  accept;
  logic                  start_ok;
  logic                  len_too_big;

  assign accept      = in_valid && in_ready;
  assign start_ok    = start && (state == IDLE || state == DONE || state == ERROR);
  assign len_word    = {len_q[7:0], in_data};
  assign len_too_big = {1'b0, len_word} > DEPTH_LIMIT;
  assign count_next  = count_q + 1'b1;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] chk_acc;
  logic       chk_en;

  assign chk_en = accept && (state != CHK);

  loader_xor_acc u_xor_acc (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_ok),
    .enable (chk_en),
    .byte_in(in_data),
    .acc    (chk_acc)
  );
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Frame sequencing: walk the header, the records and the optional checksum
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (start) next_state = LEN_HI;
      LEN_HI: if (accept) next_state = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if (len_too_big)
            next_state = ERROR;
          else if (len_word == '0)
            next_state = AFTER_LAST;
          else
            next_state = OPC_HI;
        end
      end
      OPC_HI: if (accept) next_state = OPC_LO;
      OPC_LO: if (accept) next_state = OPR_HI;
      OPR_HI: if (accept) next_state = OPR_LO;
      OPR_LO: if (accept) next_state = WRITE;
      WRITE:  next_state = (count_next == len_q) ? AFTER_LAST : OPC_HI;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHK:    if (accept) next_state = (in_data == chk_acc) ? DONE : ERROR;
`endif
      DONE:   next_state = start ? LEN_HI : IDLE;
      ERROR:  if (start) next_state = LEN_HI;
      default: next_state = IDLE;
    endcase
  end

  // Handshake and strobes decoded straight from the current state
  always_comb begin
    in_ready = accepts_bytes(state);
    mem_we   = (state == WRITE);
    done     = (state == DONE);
  end

  // Length, record counter and byte assembly registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q   <= '0;
      count_q <= '0;
      opc_q   <= '0;
      opr_q   <= '0;
    end else begin
      if (start_ok) begin
        len_q   <= '0;
        count_q <= '0;
      end
      if (accept && (state == LEN_HI || state == LEN_LO))
        len_q <= len_word;
      if (accept && (state == OPC_HI || state == OPC_LO))
        opc_q <= {opc_q[7:0], in_data};
      if (accept && (state == OPR_HI || state == OPR_LO))
        opr_q <= {opr_q[7:0], in_data};
      if (state == WRITE)
        count_q <= count_next;
    end
  end

  // Write port registers: captured as a record completes and held until the next one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr    <= '0;
      mem_opcode  <= '0;
      mem_operand <= '0;
    end else if (accept && state == OPR_LO) begin
      mem_addr    <= count_q;
      mem_opcode  <= opc_q;
      mem_operand <= {opr_q[7:0], in_data};
    end
  end

  // Processor hold and sticky fault flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_hold <= 1'b1;
      error    <= 1'b0;
    end else begin
      if (start_ok) begin
        cpu_hold <= 1'b1;
        error    <= 1'b0;
      end
      if (next_state == DONE)
        cpu_hold <= 1'b0;
      if (next_state == ERROR)
        error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames from the test plan
// plus randomized frames, checked against a frame-level reference model.
// Honours PROGRAM_LOADER_CHECKSUM_EN when the design is built with it.
module tb_program_loader;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_opcode;
  logic [15:0] mem_operand;
  logic        cpu_hold;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  program_loader #(.DEPTH(DEPTH), .DATA_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_opcode (mem_opcode),
    .mem_operand(mem_operand),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  int check_count = 0;
  int pass_count  = 0;

  logic [7:0]  frame_q[$];
  logic [47:0] exp_q[$];
  logic [47:0] obs_q[$];
  int          done_count     = 0;
  int          hold_bad       = 0;
  int          ready_in_write = 0;

  // Record every write and done pulse seen on the outputs, away from the clock edge
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        obs_q.push_back({mem_addr, mem_opcode, mem_operand});
        if (in_ready) ready_in_write++;
      end
      if (done) begin
        done_count++;
        if (cpu_hold) hold_bad++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed === expected)
      pass_count++;
    else
      $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
  endtask

  task automatic appendChk(input bit bad);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (frame_q[i]) x ^= frame_q[i];
    frame_q.push_back(bad ? (x ^ 8'h5A) : x);
`endif
  endtask

  task automatic buildFrame(input int n, input bit bad);
    frame_q.delete();
    frame_q.push_back(8'(n >> 8));
    frame_q.push_back(8'(n));
    if (n <= DEPTH) begin
      for (int i = 0; i < 4 * n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
      appendChk(bad);
    end
  endtask

  task automatic startLoad();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("hold_after_start", 64'(cpu_hold), 64'd1);
    checkOutput("error_cleared", 64'(error), 64'd0);
  endtask

  // Stream frame_q; mode 0 = always valid, 1 = valid toggling, 2 = random valid plus stray starts
  task automatic applyStimulus(input int mode);
    int idx;
    int budget;
    int n;
    bit pend;
    bit tog;
    n = int'({frame_q[0], frame_q[1]});
    idx = 0;
    budget = 0;
    pend = 1'b0;
    tog = 1'b1;
    while (idx < frame_q.size() && budget < 20000) begin
      @(negedge clk);
      budget++;
      if (pend) begin
        checkOutput("write_latency", 64'(mem_we), 64'd1);
        pend = 1'b0;
      end
      case (mode)
        0: in_valid = 1'b1;
        1: begin in_valid = tog; tog = !tog; end
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      start = (mode == 2) && ($urandom_range(0, 7) == 0);
      in_data = frame_q[idx];
      if (in_valid && in_ready) begin
        idx++;
        if (n <= DEPTH && idx >= 6 && (idx - 2) % 4 == 0 && (idx - 2) / 4 <= n) pend = 1'b1;
      end
    end
    @(negedge clk);
    if (pend) checkOutput("write_latency", 64'(mem_we), 64'd1);
    in_valid = 1'b0;
    start = 1'b0;
    if (idx != frame_q.size())
      checkOutput("stimulus_timeout", 64'(idx), 64'(frame_q.size()));
  endtask

  // Reference model: expected writes and outcome derived from the frame bytes
  task automatic runFrame(input int mode);
    int n;
    bit exp_err;
    int base_obs;
    int base_done;
    int base_hold;
    int base_riw;
    n = int'({frame_q[0], frame_q[1]});
    exp_err = (n > DEPTH);
    exp_q.delete();
    if (!exp_err)
      for (int i = 0; i < n; i++)
        exp_q.push_back({16'(i), frame_q[2+4*i], frame_q[3+4*i], frame_q[4+4*i], frame_q[5+4*i]});
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (!exp_err) begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < frame_q.size() - 1; i++) x ^= frame_q[i];
      exp_err = (x != frame_q[frame_q.size()-1]);
    end
`endif
    base_obs  = obs_q.size();
    base_done = done_count;
    base_hold = hold_bad;
    base_riw  = ready_in_write;
    startLoad();
    applyStimulus(mode);
    repeat (4) @(negedge clk);
    checkOutput("write_count", 64'(obs_q.size() - base_obs), 64'(exp_q.size()));
    foreach (exp_q[i])
      if (base_obs + i < obs_q.size())
        checkOutput("write_data", 64'(obs_q[base_obs+i]), 64'(exp_q[i]));
    checkOutput("done_pulses", 64'(done_count - base_done), exp_err ? 64'd0 : 64'd1);
    checkOutput("hold_during_done", 64'(hold_bad - base_hold), 64'd0);
    checkOutput("ready_in_write", 64'(ready_in_write - base_riw), 64'd0);
    checkOutput("error_flag", 64'(error), 64'(exp_err));
    checkOutput("cpu_hold", 64'(cpu_hold), 64'(exp_err));
    checkOutput("ready_at_rest", 64'(in_ready), 64'd0);
  endtask

  task automatic loadDirected();
    frame_q = '{8'h00, 8'h02, 8'h10, 8'h01, 8'h00, 8'h05, 8'h30, 8'h02, 8'hAB, 8'hCD};
    appendChk(1'b0);
  endtask

  initial begin
    int base_obs;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("reset_cpu_hold", 64'(cpu_hold), 64'd1);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset_mem_we", 64'(mem_we), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_error", 64'(error), 64'd0);
    checkOutput("reset_mem_addr", 64'(mem_addr), 64'd0);

    $display("[TB] directed two-record frame");
    loadDirected();
    runFrame(0);
    runFrame(1);

    $display("[TB] over-length frame then recovery");
    frame_q = '{8'h01, 8'h01};
    runFrame(0);
    loadDirected();
    runFrame(2);

    $display("[TB] full-depth and empty frames");
    buildFrame(DEPTH, 1'b0);
    runFrame(0);
    buildFrame(0, 1'b0);
    runFrame(2);

    $display("[TB] reset in the middle of record 1");
    frame_q = '{8'h00, 8'h02, 8'h10, 8'h01, 8'h00, 8'h05, 8'h30, 8'h02, 8'hAB};
    base_obs = obs_q.size();
    startLoad();
    applyStimulus(0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midreset_cpu_hold", 64'(cpu_hold), 64'd1);
    checkOutput("midreset_in_ready", 64'(in_ready), 64'd0);
    checkOutput("midreset_mem_we", 64'(mem_we), 64'd0);
    checkOutput("midreset_writes", 64'(obs_q.size() - base_obs), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midreset_idle_ready", 64'(in_ready), 64'd0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    $display("[TB] checksum frames");
    frame_q = '{8'h00, 8'h01, 8'h70, 8'h00, 8'h00, 8'h03, 8'h72};
    runFrame(0);
    frame_q = '{8'h00, 8'h01, 8'h70, 8'h00, 8'h00, 8'h03, 8'h00};
    runFrame(0);
`endif

    $display("[TB] randomized frames");
    for (int t = 0; t < 12; t++) begin
      int n;
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(257, 400)) : int'($urandom_range(0, 6));
      buildFrame(n, $urandom_range(0, 3) == 0);
      runFrame(int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
